trigger_event_sequencer: RTL and testbench

- Controls one trigger transaction from the DI2C trigger receiver through the local DAQ and back to the ready state.
- Sequence: a trigger pulse starts DAQ acquisition; the block then collects the decoded packet fields and checks CRC and serial continuity. It presents an event header to the DAQ packer, then releases the receiver busy with a busy_clear pulse once the DAQ reports done.
- Holds the receiver off (drives its iBusy) whenever an event is in flight.

---
 rtl/trigger_event_sequencer.sv | 162 ++++++++++++++++
 tb/tb_trigger_event_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_event_sequencer.sv
// Sequences one trigger transaction: receiver trigger -> DAQ start -> packet check ->
// event header handshake -> wait for DAQ done -> busy_clear pulse back to the receiver.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | ready, waiting for a trigger pulse
// S_WAIT_END | acquisition running, waiting for end_flag or timer expiry
// S_HDR      | event header presented, waiting for hdr_ready
// S_ACQ      | header accepted, waiting for DAQ done (live or recorded)
// S_RELEASE  | busy_clear asserted for CLR_PULSE_LEN cycles
module trigger_event_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned CLR_PULSE_LEN  = 4,
    parameter bit          CHECK_SERIAL   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trigger,
    input  logic        end_flag,
    input  logic        crc_status,
    input  logic [7:0]  sub_system_id,
    input  logic [7:0]  trigger_type,
    input  logic [31:0] trigger_serial,
    output logic        busy_clear,
    output logic        hold_off,
    output logic        daq_start,
    input  logic        daq_done,
    output logic        hdr_valid,
    input  logic        hdr_ready,
    output logic [7:0]  hdr_sub_system_id,
    output logic [7:0]  hdr_trigger_type,
    output logic [31:0] hdr_trigger_serial,
    output logic [3:0]  hdr_flags,
    output logic [15:0] err_crc_cnt,
    output logic [15:0] err_gap_cnt,
    output logic [15:0] err_timeout_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_END,
        S_HDR,
        S_ACQ,
        S_RELEASE
    } state_t;

    // Down-counter expiring at zero gives the same expiry cycle as counting 0..TIMEOUT_CYCLES-1.
    localparam logic [19:0] TMR_LOAD = 20'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  CLR_LOAD = 4'(CLR_PULSE_LEN - 1);

    state_t      state;
    logic [19:0] timer;
    logic [3:0]  clr_cnt;
    logic        first_seen;
    logic [31:0] expected_serial;
    logic        done_seen;
    logic        overrun;

    logic gap_now;
    logic accept;

    assign gap_now = CHECK_SERIAL && first_seen && crc_status
                     && (trigger_serial != expected_serial);
    assign accept  = hdr_valid && hdr_ready;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state              <= S_IDLE;
            timer              <= '0;
            clr_cnt            <= '0;
            first_seen         <= 1'b0;
            expected_serial    <= '0;
            done_seen          <= 1'b0;
            overrun            <= 1'b0;
            busy_clear         <= 1'b0;
            hold_off           <= 1'b0;
            daq_start          <= 1'b0;
            hdr_valid          <= 1'b0;
            hdr_sub_system_id  <= '0;
            hdr_trigger_type   <= '0;
            hdr_trigger_serial <= '0;
            hdr_flags          <= '0;
            err_crc_cnt        <= '0;
            err_gap_cnt        <= '0;
            err_timeout_cnt    <= '0;
        end else begin
            daq_start <= 1'b0;
            // An early done or a second trigger must not be lost while an event is in flight.
            if (state != S_IDLE && daq_done) done_seen <= 1'b1;
            if (state != S_IDLE && trigger)  overrun   <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        daq_start <= 1'b1;
                        hold_off  <= 1'b1;
                        done_seen <= 1'b0;
                        overrun   <= 1'b0;
                        timer     <= TMR_LOAD;
                        state     <= S_WAIT_END;
                    end
                end
                S_WAIT_END: begin
                    if (end_flag) begin
                        hdr_sub_system_id  <= sub_system_id;
                        hdr_trigger_type   <= trigger_type;
                        hdr_trigger_serial <= trigger_serial;
                        hdr_flags          <= {overrun | trigger, 1'b0, gap_now, crc_status};
                        if (crc_status) begin
                            expected_serial <= trigger_serial + 32'd1;
                            first_seen      <= 1'b1;
                        end
                        hdr_valid <= 1'b1;
                        state     <= S_HDR;
                    end else if (timer == 20'd0) begin
                        hdr_sub_system_id  <= '0;
                        hdr_trigger_type   <= '0;
                        hdr_trigger_serial <= '0;
                        hdr_flags          <= {overrun | trigger, 1'b1, 1'b0, 1'b0};
                        hdr_valid          <= 1'b1;
                        state              <= S_HDR;
                    end else begin
                        timer <= timer - 20'd1;
                    end
                end
                S_HDR: begin
                    if (accept) begin
                        hdr_valid <= 1'b0;
                        if (!hdr_flags[0] && !hdr_flags[2]) err_crc_cnt <= sat_inc(err_crc_cnt);
                        if (hdr_flags[1]) err_gap_cnt     <= sat_inc(err_gap_cnt);
                        if (hdr_flags[2]) err_timeout_cnt <= sat_inc(err_timeout_cnt);
                        state <= S_ACQ;
                    end else if (trigger) begin
                        hdr_flags[3] <= 1'b1;
                    end
                end
                S_ACQ: begin
                    if (done_seen || daq_done) begin
                        busy_clear <= 1'b1;
                        clr_cnt    <= CLR_LOAD;
                        state      <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (clr_cnt == 4'd0) begin
                        busy_clear <= 1'b0;
                        hold_off   <= 1'b0;
                        state      <= S_IDLE;
                    end else begin
                        clr_cnt <= clr_cnt - 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trigger_event_sequencer.sv
// Scoreboard bench for trigger_event_sequencer: expected headers are queued at end_flag
// time and compared when the packer handshake completes.
module tb_trigger_event_sequencer;

    localparam int CLR = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        trigger, end_flag, crc_status, daq_done, hdr_ready;
    logic [7:0]  sub_system_id, trigger_type;
    logic [31:0] trigger_serial;
    logic        busy_clear, hold_off, daq_start, hdr_valid;
    logic [7:0]  hdr_sub_system_id, hdr_trigger_type;
    logic [31:0] hdr_trigger_serial;
    logic [3:0]  hdr_flags;
    logic [15:0] err_crc_cnt, err_gap_cnt, err_timeout_cnt;

    trigger_event_sequencer #(
        .TIMEOUT_CYCLES(50),
        .CLR_PULSE_LEN (CLR),
        .CHECK_SERIAL  (1'b1)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .trigger           (trigger),
        .end_flag          (end_flag),
        .crc_status        (crc_status),
        .sub_system_id     (sub_system_id),
        .trigger_type      (trigger_type),
        .trigger_serial    (trigger_serial),
        .busy_clear        (busy_clear),
        .hold_off          (hold_off),
        .daq_start         (daq_start),
        .daq_done          (daq_done),
        .hdr_valid         (hdr_valid),
        .hdr_ready         (hdr_ready),
        .hdr_sub_system_id (hdr_sub_system_id),
        .hdr_trigger_type  (hdr_trigger_type),
        .hdr_trigger_serial(hdr_trigger_serial),
        .hdr_flags         (hdr_flags),
        .err_crc_cnt       (err_crc_cnt),
        .err_gap_cnt       (err_gap_cnt),
        .err_timeout_cnt   (err_timeout_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  id;
        logic [7:0]  typ;
        logic [31:0] ser;
        logic [3:0]  flags;
    } hdr_t;

    hdr_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_starts = 0;
    int   n_bc = 0;
    int   bc_len = 0;
    logic bc_prev = 1'b0;

    logic        m_first = 1'b0;
    logic [31:0] m_exp = '0;
    int          m_crc = 0, m_gap = 0, m_to = 0;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Header scoreboard and pulse monitors, sampled mid-cycle.
    always @(negedge clk) begin
        hdr_t e;
        if (reset) begin
            if (daq_start) n_starts++;
            if (busy_clear) begin
                bc_len++;
            end else if (bc_prev) begin
                check_value("busy_clear_len", bc_len, CLR);
                check_value("hold_off_fall", hold_off, 0);
                bc_len = 0;
                n_bc++;
            end
            bc_prev = busy_clear;
            if (hdr_valid && hdr_ready) begin
                if (exp_q.size() == 0) begin
                    check_value("hdr_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_value("hdr", {hdr_sub_system_id, hdr_trigger_type, hdr_trigger_serial, hdr_flags},
                                {e.id, e.typ, e.ser, e.flags});
                end
            end
        end else begin
            bc_len  = 0;
            bc_prev = 1'b0;
        end
    end

    task automatic push_expected(input logic [7:0] id, input logic [7:0] typ, input logic [31:0] ser,
                                 input logic crc, input logic ovr);
        hdr_t e;
        logic gap;
        gap     = m_first && crc && (ser != m_exp);
        e.id    = id;
        e.typ   = typ;
        e.ser   = ser;
        e.flags = {ovr, 1'b0, gap, crc};
        if (crc) begin
            m_exp   = ser + 32'd1;
            m_first = 1'b1;
        end else begin
            m_crc++;
        end
        if (gap) m_gap++;
        exp_q.push_back(e);
    endtask

    task automatic drive_end(input logic [7:0] id, input logic [7:0] typ, input logic [31:0] ser,
                             input logic crc);
        end_flag       = 1'b1;
        crc_status     = crc;
        sub_system_id  = id;
        trigger_type   = typ;
        trigger_serial = ser;
    endtask

    task automatic clear_end();
        end_flag       = 1'b0;
        crc_status     = 1'b0;
        sub_system_id  = '0;
        trigger_type   = '0;
        trigger_serial = '0;
    endtask

    task automatic wait_release();
        int n = 0;
        while (hold_off === 1'b1 && n < 200) begin
            cyc();
            n++;
        end
        check_value("release_bound", n < 200, 1);
    endtask

    task automatic check_counters(input string tag);
        check_value({tag, "_crc_cnt"}, err_crc_cnt, m_crc);
        check_value({tag, "_gap_cnt"}, err_gap_cnt, m_gap);
        check_value({tag, "_to_cnt"}, err_timeout_cnt, m_to);
    endtask

    task automatic run_event(input logic [7:0] id, input logic [7:0] typ, input logic [31:0] ser,
                             input logic crc, input int end_dly, input int done_dly);
        int starts0;
        starts0 = n_starts;
        trigger = 1'b1;
        cyc();
        trigger = 1'b0;
        check_value("daq_start_next", daq_start, 1);
        check_value("hold_off_on", hold_off, 1);
        repeat (end_dly - 1) cyc();
        drive_end(id, typ, ser, crc);
        push_expected(id, typ, ser, crc, 1'b0);
        cyc();
        clear_end();
        repeat (done_dly) cyc();
        daq_done = 1'b1;
        cyc();
        daq_done = 1'b0;
        wait_release();
        check_value("one_daq_start", n_starts - starts0, 1);
        check_counters("evt");
    endtask

    initial begin
        int          starts0;
        int          bc0;
        logic        stable;
        logic [47:0] snap;

        reset     = 1'b0;
        trigger   = 1'b0;
        daq_done  = 1'b0;
        hdr_ready = 1'b1;
        clear_end();
        repeat (3) cyc();
        check_value("reset_outputs", {busy_clear, hold_off, daq_start, hdr_valid, hdr_sub_system_id,
                    hdr_trigger_type, hdr_trigger_serial, hdr_flags}, 0);
        check_value("reset_counters", {err_crc_cnt, err_gap_cnt, err_timeout_cnt}, 0);
        reset = 1'b1;
        cyc();

        // good packet, then serial continuity and wrap
        run_event(8'h12, 8'h03, 32'h5, 1'b1, 40, 10);
        run_event(8'h12, 8'h03, 32'h6, 1'b1, 5, 2);
        run_event(8'h12, 8'h03, 32'h8, 1'b1, 5, 2);
        run_event(8'h21, 8'h04, 32'hFFFF_FFFF, 1'b1, 7, 0);
        run_event(8'h21, 8'h04, 32'h0, 1'b1, 3, 1);

        // CRC failure does not advance the expected serial
        run_event(8'h30, 8'h01, 32'h8, 1'b1, 4, 2);
        run_event(8'h30, 8'h01, 32'h9, 1'b0, 4, 2);
        run_event(8'h30, 8'h01, 32'hA, 1'b1, 4, 2);

        // timeout: no end_flag, header appears 51 cycles after the trigger cycle
        trigger = 1'b1;
        cyc();
        trigger = 1'b0;
        repeat (49) cyc();
        check_value("to_hdr_early", hdr_valid, 0);
        exp_q.push_back('{id: 8'h0, typ: 8'h0, ser: 32'h0, flags: 4'b0100});
        m_to++;
        cyc();
        check_value("to_hdr_cycle51", hdr_valid, 1);
        daq_done = 1'b1;
        cyc();
        daq_done = 1'b0;
        wait_release();
        check_counters("timeout");

        // end_flag in the expiry cycle wins
        run_event(8'h44, 8'h02, 32'hB, 1'b1, 50, 2);

        // early done, stalled header, overrun trigger during HDR
        starts0 = n_starts;
        trigger = 1'b1;
        cyc();
        trigger = 1'b0;
        repeat (4) cyc();
        daq_done = 1'b1;
        cyc();
        daq_done = 1'b0;
        repeat (4) cyc();
        hdr_ready = 1'b0;
        drive_end(8'h55, 8'h0A, 32'hC, 1'b1);
        push_expected(8'h55, 8'h0A, 32'hC, 1'b1, 1'b1);
        cyc();
        clear_end();
        check_value("stall_hdr_valid", hdr_valid, 1);
        snap   = {hdr_sub_system_id, hdr_trigger_type, hdr_trigger_serial};
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) trigger = 1'b1;
            cyc();
            trigger = 1'b0;
            if (hdr_valid !== 1'b1 || {hdr_sub_system_id, hdr_trigger_type, hdr_trigger_serial} !== snap)
                stable = 1'b0;
        end
        check_value("hdr_stable", stable, 1);
        hdr_ready = 1'b1;
        cyc();
        check_value("hdr_valid_drop", hdr_valid, 0);
        check_value("acq_no_clear", busy_clear, 0);
        cyc();
        check_value("release_after_acq", busy_clear, 1);
        wait_release();
        check_value("overrun_one_start", n_starts - starts0, 1);

        // reset during ACQ aborts the event without a busy_clear pulse
        trigger = 1'b1;
        cyc();
        trigger = 1'b0;
        repeat (9) cyc();
        drive_end(8'h66, 8'h07, 32'hD, 1'b1);
        push_expected(8'h66, 8'h07, 32'hD, 1'b1, 1'b0);
        cyc();
        clear_end();
        repeat (3) cyc();
        bc0   = n_bc;
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        check_value("abort_outputs", {busy_clear, hold_off, daq_start, hdr_valid, hdr_sub_system_id,
                    hdr_trigger_type, hdr_trigger_serial, hdr_flags}, 0);
        m_first = 1'b0;
        m_exp   = '0;
        m_crc   = 0;
        m_gap   = 0;
        m_to    = 0;
        check_counters("abort");
        daq_done = 1'b1;
        cyc();
        daq_done = 1'b0;
        repeat (10) cyc();
        check_value("abort_no_clear", n_bc - bc0, 0);
        check_value("abort_idle", hold_off, 0);
        run_event(8'h77, 8'h08, 32'h64, 1'b1, 6, 1);

        check_value("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
